// File: rtl/vga_console_writer.sv
// vga_console_writer
//   Writer side of the vga character-RAM write port. Accepts a valid/ready
//   byte stream, keeps a text cursor, interprets control codes and emits
//   single-cycle character writes. Clears the whole screen after reset and
//   on form feed, since the vga RAM powers up holding garbage.
//
//   Optional feature macro: CONSOLE_CLEAR_LINE_EN -- when defined, every row
//   advance blanks the newly entered row before accepting more input.
//
// Ports
//   CLK               in   system clock, rising edge
//   RST               in   asynchronous active-high reset
//   in_data[7:0]      in   byte from CPU (ASCII or control code)
//   in_valid          in   in_data valid
//   in_ready          out  byte accepted when in_valid && in_ready
//   write_char[7:0]   out  character to store
//   write_char_pos    out  linear position row*COLS+col
//   write_char_strobe out  one-cycle write pulse
//   cursor_pos        out  current linear cursor position
module vga_console_writer #(
  parameter int COLS  = 80,
  parameter int ROWS  = 25,
  parameter int POS_W = 11
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       write_char,
  output logic [POS_W-1:0] write_char_pos,
  output logic             write_char_strobe,
  output logic [POS_W-1:0] cursor_pos
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int TOTAL = COLS * ROWS;

`ifdef CONSOLE_CLEAR_LINE_EN
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_CLEAR_LINE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_CLEAR} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [POS_W-1:0] row_base;
  logic [POS_W-1:0] clr_addr;

  logic             at_last_col;
  logic             at_last_row;
  logic [RW-1:0]    nl_row;
  logic [POS_W-1:0] nl_base;
  logic [POS_W-1:0] cur_pos;
  logic             accept;
  logic             printable;
  logic             newline;

  // row_base tracks row*COLS incrementally so no multiplier is needed
  always_comb begin
    at_last_col = (col == CW'(COLS - 1));
    at_last_row = (row == RW'(ROWS - 1));
    nl_row      = at_last_row ? '0 : row + 1'b1;
    nl_base     = at_last_row ? '0 : row_base + POS_W'(COLS);
    cur_pos     = row_base + POS_W'(col);
    accept      = in_valid && in_ready && (state == S_IDLE);
    printable   = (in_data >= 8'h20) && (in_data <= 8'h7E);
    newline     = (printable && at_last_col) || (in_data == 8'h0A);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state             <= S_CLEAR;
      clr_addr          <= '0;
      col               <= '0;
      row               <= '0;
      row_base          <= '0;
      in_ready          <= 1'b0;
      write_char        <= '0;
      write_char_pos    <= '0;
      write_char_strobe <= 1'b0;
      cursor_pos        <= '0;
    end else begin
      write_char_strobe <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (printable) begin
              write_char_strobe <= 1'b1;
              write_char        <= in_data;
              write_char_pos    <= cur_pos;
            end
            if (newline) begin
              col        <= '0;
              row        <= nl_row;
              row_base   <= nl_base;
              cursor_pos <= nl_base;
`ifdef CONSOLE_CLEAR_LINE_EN
              state      <= S_CLEAR_LINE;
              in_ready   <= 1'b0;
              clr_addr   <= nl_base;
`endif
            end else if (printable) begin
              col        <= col + 1'b1;
              cursor_pos <= cur_pos + 1'b1;
            end else begin
              case (in_data)
                8'h0D: begin
                  col        <= '0;
                  cursor_pos <= row_base;
                end
                8'h08: begin
                  if (col != '0) begin
                    col               <= col - 1'b1;
                    cursor_pos        <= cur_pos - 1'b1;
                    write_char_strobe <= 1'b1;
                    write_char        <= 8'h20;
                    write_char_pos    <= cur_pos - 1'b1;
                  end
                end
                8'h0C: begin
                  state    <= S_CLEAR;
                  in_ready <= 1'b0;
                  clr_addr <= '0;
                end
                default: ;
              endcase
            end
          end
        end

        S_CLEAR: begin
          write_char_strobe <= 1'b1;
          write_char        <= 8'h20;
          write_char_pos    <= clr_addr;
          if (clr_addr == POS_W'(TOTAL - 1)) begin
            state      <= S_IDLE;
            in_ready   <= 1'b1;
            col        <= '0;
            row        <= '0;
            row_base   <= '0;
            cursor_pos <= '0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end

`ifdef CONSOLE_CLEAR_LINE_EN
        // row_base already points at the new row; cursor sits at its col 0
        S_CLEAR_LINE: begin
          write_char_strobe <= 1'b1;
          write_char        <= 8'h20;
          write_char_pos    <= clr_addr;
          if (clr_addr == row_base + POS_W'(COLS - 1)) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
